pic_writer: RTL and testbench

Write-side counterpart of the picture ROM readers: accepts a stream of (x, y, colour) pixel writes over a valid/ready handshake and stores them into a 160x120, 2-bit-per-pixel single-port RAM (19200 words, 15-bit address, row-major). It also provides a full-screen clear that sweeps every address with a fill colour. It sits between the game-logic drawing engines and the frame RAM, which is later scanned by the same address/x/y sweep the screen readers use.

---
 rtl/pic_writer.sv | 137 +++++++++++++
 tb/tb_pic_writer.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pic_writer.sv
// Pixel write port for the 160x120 2bpp frame RAM: accepts (x, y, colour) writes
// over valid/ready and offers a full-screen clear sweep with a latched fill colour.
module pic_writer #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120,
    parameter int DROP_W = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              clear,
    input  logic [1:0]        clear_colour,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [9:0]        pix_x,
    input  logic [9:0]        pix_y,
    input  logic [1:0]        pix_colour,
    output logic [14:0]       mem_address,
    output logic [1:0]        mem_data,
    output logic              mem_wren,
    output logic              busy,
    output logic              done,
    output logic [DROP_W-1:0] drop_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FINISH
    } state_t;

    localparam logic [14:0]       TOTAL    = 15'(WIDTH * HEIGHT);
    localparam logic [9:0]        WIDTH_C  = 10'(WIDTH);
    localparam logic [9:0]        HEIGHT_C = 10'(HEIGHT);
    localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

    state_t              state_reg, state_next;
    logic [14:0]         sweep_reg, sweep_next;
    logic [1:0]          fill_reg, fill_next;
    logic [14:0]         addr_reg, addr_next;
    logic [1:0]          data_reg, data_next;
    logic                wren_reg, wren_next;
    logic                busy_reg, busy_next;
    logic                done_reg, done_next;
    logic [DROP_W-1:0]   drop_reg, drop_next;

    logic                pix_in_range;
    logic [14:0]         pix_addr;

    // Address is only used when in range, so the 15-bit product never wraps.
    assign pix_in_range = (pix_x < WIDTH_C) && (pix_y < HEIGHT_C);
    assign pix_addr     = 15'(pix_y) * 15'(WIDTH) + 15'(pix_x);
    assign pix_ready    = (state_reg == ST_IDLE) && !clear;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= ST_IDLE;
            sweep_reg <= '0;
            fill_reg  <= '0;
            addr_reg  <= '0;
            data_reg  <= '0;
            wren_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            drop_reg  <= '0;
        end else begin
            state_reg <= state_next;
            sweep_reg <= sweep_next;
            fill_reg  <= fill_next;
            addr_reg  <= addr_next;
            data_reg  <= data_next;
            wren_reg  <= wren_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            drop_reg  <= drop_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        sweep_next = sweep_reg;
        fill_next  = fill_reg;
        addr_next  = addr_reg;
        data_next  = data_reg;
        wren_next  = 1'b0;
        drop_next  = drop_reg;

        case (state_reg)
            ST_IDLE: begin
                if (clear) begin
                    // Address 0 is written on the accepting edge, so the counter starts at 1.
                    state_next = ST_CLEAR;
                    fill_next  = clear_colour;
                    addr_next  = '0;
                    data_next  = clear_colour;
                    wren_next  = 1'b1;
                    sweep_next = 15'd1;
                end else if (pix_valid) begin
                    if (pix_in_range) begin
                        addr_next = pix_addr;
                        data_next = pix_colour;
                        wren_next = 1'b1;
                    end else if (drop_reg != DROP_MAX) begin
                        drop_next = drop_reg + 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                if (sweep_reg == TOTAL) begin
                    state_next = ST_FINISH;
                    sweep_next = '0;
                end else begin
                    addr_next  = sweep_reg;
                    data_next  = fill_reg;
                    wren_next  = 1'b1;
                    sweep_next = sweep_reg + 15'd1;
                end
            end
            ST_FINISH: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        busy_next = (state_next == ST_CLEAR);
        done_next = (state_next == ST_FINISH);
    end

    assign mem_address = addr_reg;
    assign mem_data    = data_reg;
    assign mem_wren    = wren_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign drop_count  = drop_reg;

endmodule

// File: tb/tb_pic_writer.sv
// Bench for pic_writer: randomized pixel streams and clear sweeps checked against
// a frame-level model (row-major address arithmetic, saturating drop count).
module tb_pic_writer;

    localparam int W        = 160;
    localparam int H        = 120;
    localparam int NPIX     = W * H;
    localparam int DROP_MAX = 255;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        clear = 1'b0;
    logic [1:0]  clear_colour = '0;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic [9:0]  pix_x = '0;
    logic [9:0]  pix_y = '0;
    logic [1:0]  pix_colour = '0;
    logic [14:0] mem_address;
    logic [1:0]  mem_data;
    logic        mem_wren;
    logic        busy;
    logic        done;
    logic [7:0]  drop_count;

    int checks = 0;
    int failures = 0;
    int m_addr = 0;
    int m_data = 0;
    int m_drop = 0;

    always #5 clk = ~clk;

    pic_writer #(.WIDTH(W), .HEIGHT(H), .DROP_W(8)) dut (
        .clk(clk), .resetn(resetn), .clear(clear), .clear_colour(clear_colour),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y),
        .pix_colour(pix_colour), .mem_address(mem_address), .mem_data(mem_data),
        .mem_wren(mem_wren), .busy(busy), .done(done), .drop_count(drop_count)
    );

    task automatic test_reset();
        resetn = 1'b0;
        #3;
        checks++;
        if (mem_address !== 15'd0 || mem_data !== 2'd0 || mem_wren !== 1'b0 || busy !== 1'b0 ||
            done !== 1'b0 || drop_count !== 8'd0 || pix_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset addr=%0d data=%0d wren=%0b busy=%0b done=%0b drop=%0d ready=%0b required all 0, ready=1",
                     mem_address, mem_data, mem_wren, busy, done, drop_count, pix_ready);
        end
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        m_addr = 0; m_data = 0; m_drop = 0;
        $display("reset released");
    endtask

    task automatic test_single_pixel();
        @(negedge clk);
        pix_valid = 1'b1; pix_x = 10'd5; pix_y = 10'd2; pix_colour = 2'd3;
        #1;
        checks++;
        if (pix_ready !== 1'b1) begin
            failures++;
            $display("FAIL single_ready got %0b required 1", pix_ready);
        end
        @(negedge clk);
        pix_valid = 1'b0;
        checks++;
        if (mem_wren !== 1'b1 || mem_address !== 15'd325 || mem_data !== 2'd3) begin
            failures++;
            $display("FAIL single_write wren=%0b addr=%0d data=%0d required 1/325/3", mem_wren, mem_address, mem_data);
        end
        @(negedge clk);
        checks++;
        if (mem_wren !== 1'b0 || mem_address !== 15'd325) begin
            failures++;
            $display("FAIL single_idle wren=%0b addr=%0d required 0/325", mem_wren, mem_address);
        end
        m_addr = 325; m_data = 3;
        $display("pixel x=5 y=2 c=3 written at 325");
    endtask

    task automatic test_back_to_back();
        int xs[3] = '{0, 159, 159};
        int ys[3] = '{0, 119, 0};
        int ea[3] = '{0, 19199, 159};
        int cs[3];
        for (int i = 0; i <= 3; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if (mem_wren !== 1'b1 || mem_address !== 15'(ea[i-1]) || mem_data !== 2'(cs[i-1])) begin
                    failures++;
                    $display("FAIL b2b[%0d] wren=%0b addr=%0d data=%0d required 1/%0d/%0d",
                             i - 1, mem_wren, mem_address, mem_data, ea[i-1], cs[i-1]);
                end
            end
            if (i < 3) begin
                cs[i] = int'($urandom_range(0, 3));
                pix_valid = 1'b1; pix_x = 10'(xs[i]); pix_y = 10'(ys[i]); pix_colour = 2'(cs[i]);
                #1;
                checks++;
                if (pix_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_ready[%0d] got %0b required 1", i, pix_ready);
                end
                $display("pixel x=%0d y=%0d c=%0d expect addr %0d", xs[i], ys[i], cs[i], ea[i]);
            end else begin
                pix_valid = 1'b0;
            end
        end
        checks++;
        if (drop_count !== 8'd0) begin
            failures++;
            $display("FAIL b2b_drop got %0d required 0", drop_count);
        end
        m_addr = 159; m_data = cs[2];
    endtask

    task automatic test_out_of_range();
        int xs[3] = '{160, 0, 1023};
        int ys[3] = '{0, 120, 1023};
        for (int i = 0; i <= 3; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if (mem_wren !== 1'b0 || mem_address !== 15'(m_addr) || mem_data !== 2'(m_data)) begin
                    failures++;
                    $display("FAIL oor[%0d] wren=%0b addr=%0d data=%0d required 0/%0d/%0d",
                             i - 1, mem_wren, mem_address, mem_data, m_addr, m_data);
                end
            end
            if (i < 3) begin
                pix_valid = 1'b1; pix_x = 10'(xs[i]); pix_y = 10'(ys[i]); pix_colour = 2'd1;
                #1;
                checks++;
                if (pix_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL oor_ready[%0d] got %0b required 1", i, pix_ready);
                end
                $display("pixel x=%0d y=%0d out of range, expect drop", xs[i], ys[i]);
            end else begin
                pix_valid = 1'b0;
            end
        end
        checks++;
        if (drop_count !== 8'd3) begin
            failures++;
            $display("FAIL oor_drop got %0d required 3", drop_count);
        end
        m_drop = 3;
    endtask

    task automatic test_random_pixels(input int n);
        int px, py, pc;
        logic v;
        logic exp_w = 1'b0;
        for (int i = 0; i <= n; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if (mem_wren !== exp_w || mem_address !== 15'(m_addr) || mem_data !== 2'(m_data) ||
                    drop_count !== 8'(m_drop)) begin
                    failures++;
                    $display("FAIL random[%0d] wren=%0b addr=%0d data=%0d drop=%0d required %0b/%0d/%0d/%0d",
                             i - 1, mem_wren, mem_address, mem_data, drop_count, exp_w, m_addr, m_data, m_drop);
                end
            end
            if (i < n) begin
                v  = ($urandom_range(0, 3) != 0);
                px = int'($urandom_range(0, 199));
                py = int'($urandom_range(0, 149));
                pc = int'($urandom_range(0, 3));
                pix_valid = v; pix_x = 10'(px); pix_y = 10'(py); pix_colour = 2'(pc);
                if (!v) begin
                    exp_w = 1'b0;
                end else if (px < W && py < H) begin
                    exp_w = 1'b1; m_addr = py * W + px; m_data = pc;
                end else begin
                    exp_w = 1'b0;
                    if (m_drop < DROP_MAX) m_drop++;
                end
                #1;
                checks++;
                if (pix_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL random_ready[%0d] got %0b required 1", i, pix_ready);
                end
                $display("pixel v=%0b x=%0d y=%0d c=%0d", v, px, py, pc);
            end else begin
                pix_valid = 1'b0;
            end
        end
    endtask

    task automatic test_drop_saturation();
        int bad = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (mem_wren !== 1'b0 && i > 0) bad++;
            pix_valid = 1'b1;
            pix_x = 10'($urandom_range(160, 1023));
            pix_y = 10'($urandom_range(0, 1023));
            $display("pixel x=%0d y=%0d out of range", pix_x, pix_y);
        end
        @(negedge clk);
        pix_valid = 1'b0;
        if (mem_wren !== 1'b0) bad++;
        checks++;
        if (drop_count !== 8'd255 || bad != 0) begin
            failures++;
            $display("FAIL drop_saturate drop=%0d stray_writes=%0d required 255/0", drop_count, bad);
        end
        m_drop = DROP_MAX;
    endtask

    task automatic test_clear();
        int bad = 0;
        int first_bad = -1;
        @(negedge clk);
        clear = 1'b1; clear_colour = 2'd2;
        #1;
        checks++;
        if (pix_ready !== 1'b0) begin
            failures++;
            $display("FAIL clear_ready_at_request got %0b required 0", pix_ready);
        end
        for (int k = 0; k < NPIX; k++) begin
            @(negedge clk);
            if (mem_wren !== 1'b1 || mem_address !== 15'(k) || mem_data !== 2'd2 || busy !== 1'b1 ||
                done !== 1'b0 || pix_ready !== 1'b0) begin
                if (bad == 0) first_bad = k;
                bad++;
            end
            // Requests during the sweep must be ignored.
            clear = (k < NPIX - 200) ? 1'($urandom_range(0, 1)) : 1'b0;
            pix_valid = (k < NPIX - 200) ? 1'($urandom_range(0, 1)) : 1'b0;
            pix_x = 10'($urandom_range(0, 159)); pix_y = 10'($urandom_range(0, 119));
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL clear_sweep bad_cycles=%0d first_at=%0d required 0", bad, first_bad);
        end
        @(negedge clk);
        checks++;
        if (mem_wren !== 1'b0 || busy !== 1'b0 || done !== 1'b1 || pix_ready !== 1'b0) begin
            failures++;
            $display("FAIL clear_finish wren=%0b busy=%0b done=%0b ready=%0b required 0/0/1/0",
                     mem_wren, busy, done, pix_ready);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || pix_ready !== 1'b1 || mem_address !== 15'(NPIX - 1)) begin
            failures++;
            $display("FAIL clear_return done=%0b ready=%0b addr=%0d required 0/1/%0d",
                     done, pix_ready, mem_address, NPIX - 1);
        end
        m_addr = NPIX - 1; m_data = 2;
        $display("clear colour=2 swept %0d addresses", NPIX);
    endtask

    task automatic test_clear_priority();
        int waited = 0;
        @(negedge clk);
        clear = 1'b1; clear_colour = 2'd1;
        pix_valid = 1'b1; pix_x = 10'd7; pix_y = 10'd3; pix_colour = 2'd2;
        #1;
        checks++;
        if (pix_ready !== 1'b0) begin
            failures++;
            $display("FAIL prio_ready got %0b required 0", pix_ready);
        end
        @(negedge clk);
        clear = 1'b0;
        checks++;
        if (busy !== 1'b1 || mem_wren !== 1'b1 || mem_address !== 15'd0 || mem_data !== 2'd1) begin
            failures++;
            $display("FAIL prio_sweep_start busy=%0b wren=%0b addr=%0d data=%0d required 1/1/0/1",
                     busy, mem_wren, mem_address, mem_data);
        end
        while (done !== 1'b1 && waited < NPIX + 50) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (done !== 1'b1 || waited != NPIX) begin
            failures++;
            $display("FAIL prio_done done=%0b cycles=%0d required 1/%0d", done, waited, NPIX);
        end
        @(negedge clk);
        checks++;
        if (pix_ready !== 1'b1) begin
            failures++;
            $display("FAIL prio_idle_ready got %0b required 1", pix_ready);
        end
        @(negedge clk);
        pix_valid = 1'b0;
        checks++;
        if (mem_wren !== 1'b1 || mem_address !== 15'(3 * W + 7) || mem_data !== 2'd2) begin
            failures++;
            $display("FAIL prio_held_pixel wren=%0b addr=%0d data=%0d required 1/%0d/2",
                     mem_wren, mem_address, mem_data, 3 * W + 7);
        end
        m_addr = 3 * W + 7; m_data = 2;
        $display("held pixel x=7 y=3 written after clear");
    endtask

    task automatic test_reset_mid_sweep();
        int waited = 0;
        @(negedge clk);
        clear = 1'b1; clear_colour = 2'd3;
        @(negedge clk);
        clear = 1'b0;
        while (mem_address !== 15'd5000 && waited < 6000) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (mem_address !== 15'd5000) begin
            failures++;
            $display("FAIL midreset_reach addr=%0d required 5000", mem_address);
        end
        resetn = 1'b0;
        #1;
        checks++;
        if (mem_address !== 15'd0 || mem_data !== 2'd0 || mem_wren !== 1'b0 || busy !== 1'b0 ||
            done !== 1'b0 || drop_count !== 8'd0) begin
            failures++;
            $display("FAIL midreset_values addr=%0d data=%0d wren=%0b busy=%0b done=%0b drop=%0d required all 0",
                     mem_address, mem_data, mem_wren, busy, done, drop_count);
        end
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        m_addr = 0; m_data = 0; m_drop = 0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midreset_no_done done=%0b busy=%0b required 0/0", done, busy);
        end
        pix_valid = 1'b1; pix_x = 10'd10; pix_y = 10'd10; pix_colour = 2'd1;
        @(negedge clk);
        pix_valid = 1'b0;
        checks++;
        if (mem_wren !== 1'b1 || mem_address !== 15'(10 * W + 10) || mem_data !== 2'd1 || done !== 1'b0) begin
            failures++;
            $display("FAIL midreset_pixel wren=%0b addr=%0d data=%0d done=%0b required 1/%0d/1/0",
                     mem_wren, mem_address, mem_data, done, 10 * W + 10);
        end
        $display("reset at sweep 5000, pixel x=10 y=10 written afterwards");
    endtask

    initial begin
        test_reset();
        test_single_pixel();
        test_back_to_back();
        test_out_of_range();
        test_random_pixels(200);
        test_drop_saturation();
        test_clear();
        test_clear_priority();
        test_reset_mid_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
